mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_if.sv | 26 ++
 rtl/mul_div_unit.sv | 122 ++++++++++++
 tb/tb_mul_div_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/writeback bundle between the issue logic and the iterative multiply/divide unit.
// master drives operands and control; slave (the unit) returns status and writeback.
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] rs_val;
    logic [15:0] rt_val;
    logic [2:0]  rd_in;
    logic        kill;
    logic        ready;
    logic        busy;
    logic        wr_out;
    logic [2:0]  rd_out;
    logic [15:0] result;
    logic        excep;

    modport master (
        output start, op, rs_val, rt_val, rd_in, kill,
        input  ready, busy, wr_out, rd_out, result, excep
    );

    modport slave (
        input  start, op, rs_val, rt_val, rd_in, kill,
        output ready, busy, wr_out, rd_out, result, excep
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 16-bit unsigned multiply/divide: 16 shift-add or restoring-divide steps,
// then a one-cycle writeback pulse (or divide-by-zero exception pulse).
module mul_div_unit (
    input  logic          clk,
    input  logic          rst_n,
    mul_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [4:0]  r_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [15:0] r_mplier;
    logic [16:0] r_rem;
    logic [15:0] r_quo;
    logic [15:0] r_dvsr;
    logic [15:0] r_result;
    logic [2:0]  r_rd;
    logic        r_wr;
    logic        r_excep;

    logic        w_ready;
    logic        w_accept;
    logic        w_dbz;
    logic [31:0] w_acc_nxt;
    logic [17:0] w_diff;
    logic [16:0] w_rem_nxt;
    logic [15:0] w_quo_nxt;
    logic [4:0]  w_cnt_nxt;
    logic [15:0] w_sel;

    always_comb begin
        w_ready   = (r_state == S_IDLE) || (r_state == S_DONE);
        w_accept  = bus.start & w_ready & ~bus.kill;
        w_dbz     = bus.op[1] & (bus.rt_val == '0);
        w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        // Shifted remainder minus divisor; bit 17 acts as the borrow that selects restore.
        w_diff    = {r_rem, r_quo[15]} - {2'b00, r_dvsr};
        w_rem_nxt = w_diff[17] ? {r_rem[15:0], r_quo[15]} : w_diff[16:0];
        w_quo_nxt = {r_quo[14:0], ~w_diff[17]};
        w_cnt_nxt = r_cnt + 5'd1;
        case (r_op)
            2'b00:   w_sel = w_acc_nxt[15:0];
            2'b01:   w_sel = w_acc_nxt[31:16];
            2'b10:   w_sel = w_quo_nxt;
            default: w_sel = w_rem_nxt[15:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_result <= '0;
            r_rd     <= '0;
            r_wr     <= 1'b0;
            r_excep  <= 1'b0;
        end else begin
            r_wr    <= 1'b0;
            r_excep <= 1'b0;
            if (bus.kill) begin
                r_state <= S_IDLE;
            end else if (w_accept) begin
                r_op     <= bus.op;
                r_rd     <= bus.rd_in;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mcand  <= {16'h0000, bus.rs_val};
                r_mplier <= bus.rt_val;
                r_rem    <= '0;
                r_quo    <= bus.rs_val;
                r_dvsr   <= bus.rt_val;
                if (w_dbz) begin
                    r_state  <= S_DONE;
                    r_excep  <= 1'b1;
                    r_result <= bus.op[0] ? bus.rs_val : 16'hFFFF;
                end else begin
                    r_state <= S_CALC;
                end
            end else begin
                case (r_state)
                    S_CALC: begin
                        r_acc    <= w_acc_nxt;
                        r_mcand  <= {r_mcand[30:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[15:1]};
                        r_rem    <= w_rem_nxt;
                        r_quo    <= w_quo_nxt;
                        r_cnt    <= w_cnt_nxt;
                        if (w_cnt_nxt == 5'd16) begin
                            r_result <= w_sel;
                            r_wr     <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.ready  = w_ready;
    assign bus.busy   = (r_state == S_CALC) || (r_state == S_DONE);
    assign bus.wr_out = r_wr;
    assign bus.excep  = r_excep;
    assign bus.rd_out = r_rd;
    assign bus.result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit with hand-computed expected results.
module tb_mul_div_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_done(output int lat);
        lat = 0;
        while (!(bus.wr_out || bus.excep) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!(bus.wr_out || bus.excep)) lat = -1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] rd, output int lat);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.rd_in  = rd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.wr_out !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", bus.wr_out); end
        checks++; if (bus.excep !== 1'b0) begin errors++; $display("FAIL reset_excep got %b want 0", bus.excep); end
        checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", bus.result); end
        checks++; if (bus.rd_out !== 3'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", bus.rd_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul;
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 16'h1234; bus.rt_val = 16'h0010; bus.rd_in = 3'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL calc_status got busy=%b ready=%b want 1/0", bus.busy, bus.ready); end
        wait_done(lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL mullo_latency got %0d want 16", lat); end
        checks++; if (bus.result !== 16'h2340) begin errors++; $display("FAIL mullo_result got %h want 2340", bus.result); end
        checks++; if (bus.rd_out !== 3'd3) begin errors++; $display("FAIL mullo_rd got %0d want 3", bus.rd_out); end
        checks++; if (bus.wr_out !== 1'b1 || bus.excep !== 1'b0) begin errors++; $display("FAIL mullo_wr got wr=%b ex=%b want 1/0", bus.wr_out, bus.excep); end
        checks++; if (bus.busy !== 1'b1 || bus.ready !== 1'b1) begin errors++; $display("FAIL done_status got busy=%b ready=%b want 1/1", bus.busy, bus.ready); end
        @(posedge clk);
        #1;
        checks++; if (bus.wr_out !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_done got wr=%b busy=%b want 0/0", bus.wr_out, bus.busy); end
        checks++; if (bus.result !== 16'h2340) begin errors++; $display("FAIL result_hold got %h want 2340", bus.result); end

        run_op(2'b01, 16'hFFFF, 16'hFFFF, 3'd4, lat);
        checks++; if (lat !== 16 || bus.result !== 16'hFFFE) begin errors++; $display("FAIL mulhi got lat=%0d res=%h want 16/fffe", lat, bus.result); end
        run_op(2'b00, 16'hFFFF, 16'hFFFF, 3'd4, lat);
        checks++; if (lat !== 16 || bus.result !== 16'h0001) begin errors++; $display("FAIL mullo_ffff got lat=%0d res=%h want 16/0001", lat, bus.result); end
    endtask

    task automatic test_div;
        int lat;
        run_op(2'b10, 16'd100, 16'd7, 3'd6, lat);
        checks++; if (lat !== 16 || bus.result !== 16'h000E) begin errors++; $display("FAIL divu got lat=%0d res=%h want 16/000e", lat, bus.result); end
        checks++; if (bus.wr_out !== 1'b1 || bus.rd_out !== 3'd6) begin errors++; $display("FAIL divu_wr got wr=%b rd=%0d want 1/6", bus.wr_out, bus.rd_out); end
        run_op(2'b11, 16'd100, 16'd7, 3'd2, lat);
        checks++; if (lat !== 16 || bus.result !== 16'h0002) begin errors++; $display("FAIL remu got lat=%0d res=%h want 16/0002", lat, bus.result); end
        run_op(2'b10, 16'hFFFF, 16'h0001, 3'd2, lat);
        checks++; if (bus.result !== 16'hFFFF) begin errors++; $display("FAIL divu_by1 got %h want ffff", bus.result); end
    endtask

    task automatic test_div_zero;
        int lat;
        run_op(2'b10, 16'h0050, 16'h0000, 3'd5, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL dbz_latency got %0d want 0", lat); end
        checks++; if (bus.excep !== 1'b1 || bus.wr_out !== 1'b0) begin errors++; $display("FAIL dbz_flags got ex=%b wr=%b want 1/0", bus.excep, bus.wr_out); end
        checks++; if (bus.result !== 16'hFFFF || bus.rd_out !== 3'd5) begin errors++; $display("FAIL dbz_divu got res=%h rd=%0d want ffff/5", bus.result, bus.rd_out); end
        @(posedge clk);
        #1;
        checks++; if (bus.excep !== 1'b0 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL dbz_after got ex=%b ready=%b busy=%b want 0/1/0", bus.excep, bus.ready, bus.busy); end
        run_op(2'b11, 16'h0050, 16'h0000, 3'd1, lat);
        checks++; if (lat !== 0 || bus.result !== 16'h0050 || bus.excep !== 1'b1) begin errors++; $display("FAIL dbz_remu got lat=%0d res=%h ex=%b want 0/0050/1", lat, bus.result, bus.excep); end
    endtask

    task automatic test_kill;
        int seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 16'h0003; bus.rt_val = 16'h0003; bus.rd_in = 3'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.wr_out !== 1'b0) begin errors++; $display("FAIL kill_state got ready=%b busy=%b wr=%b want 1/0/0", bus.ready, bus.busy, bus.wr_out); end
        checks++; if (bus.result !== 16'h0050 || bus.rd_out !== 3'd7) begin errors++; $display("FAIL kill_hold got res=%h rd=%0d want 0050/7", bus.result, bus.rd_out); end
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.wr_out || bus.excep) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL kill_no_wb got %0d pulses want 0", seen); end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 16'd3; bus.rt_val = 16'd5; bus.rd_in = 3'd1;
        @(posedge clk);
        #1;
        bus.op = 2'b10; bus.rs_val = 16'd1; bus.rt_val = 16'd1; bus.rd_in = 3'd6;
        repeat (3) begin @(posedge clk); #1; end
        bus.start = 1'b0;
        wait_done(lat);
        if (lat >= 0) lat = lat + 3;
        checks++; if (lat !== 16 || bus.result !== 16'd15 || bus.rd_out !== 3'd1) begin errors++; $display("FAIL start_in_calc got lat=%0d res=%h rd=%0d want 16/000f/1", lat, bus.result, bus.rd_out); end
        bus.start = 1'b1; bus.op = 2'b10; bus.rs_val = 16'd1000; bus.rt_val = 16'd10; bus.rd_in = 3'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.ready !== 1'b0 || bus.wr_out !== 1'b0) begin errors++; $display("FAIL b2b_accept got busy=%b ready=%b wr=%b want 1/0/0", bus.busy, bus.ready, bus.wr_out); end
        wait_done(lat);
        if (lat >= 0) lat = lat + 1;
        checks++; if (lat !== 17 || bus.result !== 16'h0064 || bus.rd_out !== 3'd5) begin errors++; $display("FAIL b2b_second got spacing=%0d res=%h rd=%0d want 17/0064/5", lat, bus.result, bus.rd_out); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 16'd7; bus.rt_val = 16'd9; bus.rd_in = 3'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.wr_out !== 1'b0 || bus.excep !== 1'b0) begin errors++; $display("FAIL async_rst_status got ready=%b busy=%b wr=%b ex=%b want 1/0/0/0", bus.ready, bus.busy, bus.wr_out, bus.excep); end
        checks++; if (bus.result !== 16'h0000 || bus.rd_out !== 3'd0) begin errors++; $display("FAIL async_rst_data got res=%h rd=%0d want 0000/0", bus.result, bus.rd_out); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.wr_out) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_wb got %0d pulses want 0", seen); end
        run_op(2'b00, 16'd7, 16'd9, 3'd2, lat);
        checks++; if (lat !== 16 || bus.result !== 16'h003F || bus.rd_out !== 3'd2) begin errors++; $display("FAIL after_rst got lat=%0d res=%h rd=%0d want 16/003f/2", lat, bus.result, bus.rd_out); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.rd_in  = '0;
        bus.kill   = 1'b0;
        test_reset;
        test_mul;
        test_div;
        test_div_zero;
        test_kill;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
